pgm_wr: RTL and testbench

Write side of the packet generator module (PGM). It sits in front of `pgm_rd` in the pipeline and classifies each incoming packet by its PHV:
- template packets are written into the 128×144 PGM RAM;
- start/stop command packets drive `pgm_bypass_flag`, `pgm_sent_start_flag` and `pgm_sent_finish_flag`;
- all other packets are forwarded unchanged to `pgm_rd`.

---
 rtl/pgm_wr.sv | 235 +++++++++++++++++++++++
 tb/tb_pgm_wr.sv | 597 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_wr.sv
`default_nettype none
// ============================================================================
// Module   : pgm_wr
// Purpose  : Write side of the packet generator. Classifies every packet
//            by the PHV presented with its head word:
//              - STORE packets are written into the 128x144 template RAM,
//              - START/STOP packets drive the generation flags,
//              - everything else is forwarded unchanged with 1-cycle latency.
// Ports    : clk / rst_n (async, active-low)
//            in_wr_*  : upstream PHV + data path (head/body/tail coded [133:132])
//            out_wr_* : forwarded PHV + data path to pgm_rd
//            *_alf    : almost-full pass-through (combinational)
//            pgm_*    : generation control flags, template length, error pulse
//            wr2ram_* : registered template RAM write port
// Revision : 1.0  initial release
// ============================================================================
module pgm_wr #(
    parameter             PLATFORM = "Xilinx",
    parameter logic [7:0] LMID     = 8'd61
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1023:0]   in_wr_phv,
    input  logic            in_wr_phv_wr,
    output logic            out_wr_phv_alf,
    input  logic [133:0]    in_wr_data,
    input  logic            in_wr_data_wr,
    input  logic            in_wr_valid_wr,
    input  logic            in_wr_valid,
    output logic            out_wr_alf,
    output logic [1023:0]   out_wr_phv,
    output logic            out_wr_phv_wr,
    input  logic            in_wr_phv_alf,
    output logic [133:0]    out_wr_data,
    output logic            out_wr_data_wr,
    output logic            out_wr_valid,
    output logic            out_wr_valid_wr,
    input  logic            in_wr_alf,
    output logic            pgm_bypass_flag,
    output logic            pgm_sent_start_flag,
    output logic            pgm_sent_finish_flag,
    output logic [7:0]      pgm_tpl_len,
    output logic            pgm_err,
    output logic            wr2ram_wr,
    output logic [6:0]      wr2ram_addr,
    output logic [143:0]    wr2ram_wdata
);

    localparam logic [3:0] c_OP_STORE = 4'h1;
    localparam logic [3:0] c_OP_START = 4'h2;
    localparam logic [3:0] c_OP_STOP  = 4'h3;

    localparam logic [1:0] c_CMD_NONE  = 2'd0;
    localparam logic [1:0] c_CMD_START = 2'd1;
    localparam logic [1:0] c_CMD_STOP  = 2'd2;

    localparam logic [7:0] c_LAST_IDX  = 8'd127;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FWD   = 2'd1,
        S_STORE = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t       r_state;
    logic [1:0]   r_cmd;        // command to execute at the tail while in DROP
    logic [7:0]   r_cnt;        // words written so far in the current STORE
    logic         r_ovf;        // current STORE overran the 128-word RAM
    logic         r_tpl_valid;  // RAM holds a complete, good template

    logic         w_head;
    logic         w_tail;
    logic         w_good;
    logic         w_mid_hit;
    logic [3:0]   w_op;
    logic         w_full;
    logic [133:0] w_ram_word;
    logic [9:0]   w_pad;

    // The vendor tag has no functional effect; both targets pad the same way.
    generate
        if (PLATFORM == "Xilinx") begin : g_pad_xilinx
            assign w_pad = 10'd0;
        end else begin : g_pad_generic
            assign w_pad = 10'd0;
        end
    endgenerate

    assign out_wr_phv_alf = in_wr_phv_alf;
    assign out_wr_alf     = in_wr_alf;

    assign w_head    = in_wr_data_wr && (in_wr_data[133:132] == 2'b01);
    assign w_tail    = in_wr_data_wr && (in_wr_data[133:132] == 2'b10);
    assign w_good    = in_wr_valid_wr && in_wr_valid;
    assign w_mid_hit = (in_wr_phv[1023:1016] == LMID);
    assign w_op      = in_wr_phv[1015:1012];
    assign w_full    = r_cnt[7];   // 128 words already written

    // The last RAM slot always closes the template with a tail code, so a
    // truncated template still reads back as a well-formed packet.
    assign w_ram_word = (r_cnt == c_LAST_IDX) ? {2'b10, in_wr_data[131:0]} : in_wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state              <= S_IDLE;
            r_cmd                <= c_CMD_NONE;
            r_cnt                <= 8'd0;
            r_ovf                <= 1'b0;
            r_tpl_valid          <= 1'b0;
            out_wr_phv           <= '0;
            out_wr_phv_wr        <= 1'b0;
            out_wr_data          <= '0;
            out_wr_data_wr       <= 1'b0;
            out_wr_valid         <= 1'b0;
            out_wr_valid_wr      <= 1'b0;
            pgm_bypass_flag      <= 1'b1;
            pgm_sent_start_flag  <= 1'b0;
            pgm_sent_finish_flag <= 1'b0;
            pgm_tpl_len          <= 8'd0;
            pgm_err              <= 1'b0;
            wr2ram_wr            <= 1'b0;
            wr2ram_addr          <= 7'd0;
            wr2ram_wdata         <= '0;
        end else begin
            // Strobes and the error pulse last a single cycle.
            out_wr_phv_wr   <= 1'b0;
            out_wr_data_wr  <= 1'b0;
            out_wr_valid_wr <= 1'b0;
            wr2ram_wr       <= 1'b0;
            pgm_err         <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_head) begin
                        if (w_mid_hit && (w_op == c_OP_STORE)) begin
                            if (pgm_sent_start_flag) begin
                                // Template is being played out: leave RAM alone.
                                pgm_err <= 1'b1;
                                r_cmd   <= c_CMD_NONE;
                                r_state <= S_DROP;
                            end else begin
                                r_tpl_valid          <= 1'b0;
                                pgm_sent_finish_flag <= 1'b0;
                                r_ovf                <= 1'b0;
                                wr2ram_wr            <= 1'b1;
                                wr2ram_addr          <= 7'd0;
                                wr2ram_wdata         <= {w_pad, in_wr_data};
                                r_cnt                <= 8'd1;
                                r_state              <= S_STORE;
                            end
                        end else if (w_mid_hit && (w_op == c_OP_START)) begin
                            r_cmd   <= c_CMD_START;
                            r_state <= S_DROP;
                        end else if (w_mid_hit && (w_op == c_OP_STOP)) begin
                            r_cmd   <= c_CMD_STOP;
                            r_state <= S_DROP;
                        end else begin
                            out_wr_phv     <= in_wr_phv;
                            out_wr_phv_wr  <= in_wr_phv_wr;
                            out_wr_data    <= in_wr_data;
                            out_wr_data_wr <= 1'b1;
                            r_state        <= S_FWD;
                        end
                    end
                end

                S_FWD: begin
                    if (in_wr_data_wr) begin
                        out_wr_data    <= in_wr_data;
                        out_wr_data_wr <= 1'b1;
                    end
                    if (in_wr_valid_wr) begin
                        out_wr_valid    <= in_wr_valid;
                        out_wr_valid_wr <= 1'b1;
                    end
                    if (w_tail) begin
                        r_state <= S_IDLE;
                    end
                end

                S_STORE: begin
                    if (in_wr_data_wr) begin
                        if (!w_full) begin
                            wr2ram_wr    <= 1'b1;
                            wr2ram_addr  <= r_cnt[6:0];
                            wr2ram_wdata <= {w_pad, w_ram_word};
                            r_cnt        <= r_cnt + 8'd1;
                        end else begin
                            // Overrun: drop the word, report once per packet.
                            r_ovf       <= 1'b1;
                            r_tpl_valid <= 1'b0;
                            if (!r_ovf) begin
                                pgm_err <= 1'b1;
                            end
                        end
                    end
                    if (w_tail) begin
                        r_state <= S_IDLE;
                        if (w_full || r_ovf || !w_good) begin
                            r_tpl_valid <= 1'b0;
                            pgm_tpl_len <= 8'd0;
                        end else begin
                            r_tpl_valid <= 1'b1;
                            pgm_tpl_len <= r_cnt + 8'd1;
                        end
                    end
                end

                S_DROP: begin
                    if (w_tail) begin
                        r_state <= S_IDLE;
                        if ((r_cmd == c_CMD_START) && w_good) begin
                            if (r_tpl_valid) begin
                                pgm_sent_start_flag  <= 1'b1;
                                pgm_bypass_flag      <= 1'b0;
                                pgm_sent_finish_flag <= 1'b0;
                            end else begin
                                pgm_err <= 1'b1;
                            end
                        end else if ((r_cmd == c_CMD_STOP) && pgm_sent_start_flag) begin
                            pgm_sent_finish_flag <= 1'b1;
                            pgm_sent_start_flag  <= 1'b0;
                            pgm_bypass_flag      <= 1'b1;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pgm_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_pgm_wr
// Purpose  : Self-checking bench for pgm_wr. Packets are driven word by word,
//            a packet-level reference model predicts RAM writes, forwarded
//            words, flag values and error pulses, and a monitor collects what
//            the design actually produced for comparison.
// Revision : 1.0  initial release
// ============================================================================
module tb_pgm_wr;

    localparam logic [7:0] c_LMID = 8'd61;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1023:0]   in_wr_phv = '0;
    logic            in_wr_phv_wr = 1'b0;
    logic [133:0]    in_wr_data = '0;
    logic            in_wr_data_wr = 1'b0;
    logic            in_wr_valid_wr = 1'b0;
    logic            in_wr_valid = 1'b0;
    logic            in_wr_phv_alf = 1'b0;
    logic            in_wr_alf = 1'b0;
    logic            out_wr_phv_alf, out_wr_alf;
    logic [1023:0]   out_wr_phv;
    logic            out_wr_phv_wr;
    logic [133:0]    out_wr_data;
    logic            out_wr_data_wr, out_wr_valid, out_wr_valid_wr;
    logic            pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag;
    logic [7:0]      pgm_tpl_len;
    logic            pgm_err;
    logic            wr2ram_wr;
    logic [6:0]      wr2ram_addr;
    logic [143:0]    wr2ram_wdata;

    pgm_wr dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_wr_phv            (in_wr_phv),
        .in_wr_phv_wr         (in_wr_phv_wr),
        .out_wr_phv_alf       (out_wr_phv_alf),
        .in_wr_data           (in_wr_data),
        .in_wr_data_wr        (in_wr_data_wr),
        .in_wr_valid_wr       (in_wr_valid_wr),
        .in_wr_valid          (in_wr_valid),
        .out_wr_alf           (out_wr_alf),
        .out_wr_phv           (out_wr_phv),
        .out_wr_phv_wr        (out_wr_phv_wr),
        .in_wr_phv_alf        (in_wr_phv_alf),
        .out_wr_data          (out_wr_data),
        .out_wr_data_wr       (out_wr_data_wr),
        .out_wr_valid         (out_wr_valid),
        .out_wr_valid_wr      (out_wr_valid_wr),
        .in_wr_alf            (in_wr_alf),
        .pgm_bypass_flag      (pgm_bypass_flag),
        .pgm_sent_start_flag  (pgm_sent_start_flag),
        .pgm_sent_finish_flag (pgm_sent_finish_flag),
        .pgm_tpl_len          (pgm_tpl_len),
        .pgm_err              (pgm_err),
        .wr2ram_wr            (wr2ram_wr),
        .wr2ram_addr          (wr2ram_addr),
        .wr2ram_wdata         (wr2ram_wdata)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    typedef struct packed { logic [31:0] stamp; logic [6:0] addr; logic [143:0] wdata; } ram_e_t;
    typedef struct packed { logic [31:0] stamp; logic vwr; logic v; logic dwr; logic [133:0] data; } fwd_e_t;
    typedef struct packed { logic [31:0] stamp; logic [1023:0] phv; } phv_e_t;

    ram_e_t q_ram[$], e_ram[$];
    fwd_e_t q_fwd[$], e_fwd[$];
    phv_e_t q_phv[$], e_phv[$];
    int     obs_err = 0;
    int     exp_err = 0;
    int     checks = 0;
    int     errors = 0;

    logic [133:0] pw [0:255];
    logic [31:0]  st [0:255];

    // Reference state
    bit          m_tpl_valid, m_start, m_finish, m_bypass;
    logic [7:0]  m_len;

    // Monitor: outputs are sampled on the falling edge, away from updates.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr2ram_wr) q_ram.push_back('{cyc, wr2ram_addr, wr2ram_wdata});
            if (out_wr_data_wr || out_wr_valid_wr)
                q_fwd.push_back('{cyc, out_wr_valid_wr, out_wr_valid_wr & out_wr_valid, out_wr_data_wr, out_wr_data});
            if (out_wr_phv_wr) q_phv.push_back('{cyc, out_wr_phv});
            if (pgm_err) obs_err++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [1023:0] rand_phv();
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [1023:0] mk_phv(input logic [7:0] mid, input logic [3:0] op);
        logic [1023:0] r;
        r = rand_phv();
        r[1023:1016] = mid;
        r[1015:1012] = op;
        return r;
    endfunction

    task automatic build_pkt(input int n);
        logic [159:0] r;
        for (int i = 0; i < n; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            pw[i] = {(i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11), r[131:0]};
        end
    endtask

    task automatic idle_inputs();
        in_wr_data_wr  = 1'b0;
        in_wr_phv_wr   = 1'b0;
        in_wr_valid_wr = 1'b0;
        in_wr_valid    = 1'b0;
    endtask

    // Drives words [first,last) of the packet held in pw[]; gap is the
    // percentage chance of idle cycles (carrying junk head-coded data).
    task automatic send_words(input logic [1023:0] phv, input int n, input bit good,
                              input int gap, input int first, input int last);
        logic [159:0] r;
        for (int i = first; i < last; i++) begin
            int g;
            g = 0;
            while (gap > 0 && g < 3 && int'($urandom_range(99)) < gap) begin
                r = {$urandom, $urandom, $urandom, $urandom, $urandom};
                idle_inputs();
                in_wr_data = {2'b01, r[131:0]};
                tick();
                g++;
            end
            in_wr_data     = pw[i];
            in_wr_data_wr  = 1'b1;
            in_wr_phv      = (i == 0) ? phv : rand_phv();
            in_wr_phv_wr   = (i == 0);
            in_wr_valid_wr = (i == n - 1);
            in_wr_valid    = (i == n - 1) ? good : 1'b0;
            st[i]          = cyc;
            tick();
        end
        idle_inputs();
    endtask

    task automatic send_pkt(input logic [1023:0] phv, input int n, input bit good, input int gap);
        send_words(phv, n, good, gap, 0, n);
    endtask

    task automatic model_reset();
        m_tpl_valid = 0; m_start = 0; m_finish = 0; m_bypass = 1; m_len = 8'd0;
    endtask

    // Packet-level behaviour from the classification and command rules.
    task automatic model_pkt(input logic [1023:0] phv, input int n, input bit good);
        logic [7:0]   mid;
        logic [3:0]   op;
        logic [133:0] w;
        mid = phv[1023:1016];
        op  = phv[1015:1012];
        if (mid != c_LMID || op < 4'h1 || op > 4'h3) begin
            e_phv.push_back('{st[0] + 32'd1, phv});
            for (int i = 0; i < n; i++)
                e_fwd.push_back('{st[i] + 32'd1, (i == n - 1), (i == n - 1) && good, 1'b1, pw[i]});
        end else if (op == 4'h1) begin
            if (m_start) begin
                exp_err++;
            end else begin
                m_tpl_valid = 0;
                m_finish    = 0;
                for (int i = 0; i < n && i < 128; i++) begin
                    w = pw[i];
                    if (i == 127) w[133:132] = 2'b10;
                    e_ram.push_back('{st[i] + 32'd1, 7'(i), {10'b0, w}});
                end
                if (n > 128) begin
                    exp_err++;
                    m_tpl_valid = 0;
                    m_len = 8'd0;
                end else if (good) begin
                    m_tpl_valid = 1;
                    m_len = 8'(n);
                end else begin
                    m_tpl_valid = 0;
                    m_len = 8'd0;
                end
            end
        end else if (op == 4'h2) begin
            if (good) begin
                if (m_tpl_valid) begin
                    m_start = 1; m_bypass = 0; m_finish = 0;
                end else begin
                    exp_err++;
                end
            end
        end else begin
            if (m_start) begin
                m_finish = 1; m_start = 0; m_bypass = 1;
            end
        end
    endtask

    task automatic clear_obs();
        q_ram.delete(); e_ram.delete();
        q_fwd.delete(); e_fwd.delete();
        q_phv.delete(); e_phv.delete();
        obs_err = 0; exp_err = 0;
    endtask

    task automatic run_pkt(input logic [1023:0] phv, input int n, input bit good, input int gap);
        build_pkt(n);
        send_pkt(phv, n, good, gap);
        model_pkt(phv, n, good);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        int nz;
        rst_n = 1'b0;
        repeat (3) tick();
        nz = $countones({out_wr_phv, out_wr_phv_wr, out_wr_data, out_wr_data_wr, out_wr_valid,
                         out_wr_valid_wr, wr2ram_wr, wr2ram_addr, wr2ram_wdata, pgm_tpl_len, pgm_err});
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got %0d nonzero bits, exp 0", nz);
        end
        checks++;
        if ({pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 100", {pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag});
        end
        rst_n = 1'b1;
        model_reset();
        repeat (2) tick();
    endtask

    task automatic test_forward();
        logic [1023:0] phv;
        for (int k = 0; k < 4; k++) begin
            in_wr_alf = k[0]; in_wr_phv_alf = k[1];
            #1;
            checks++;
            if ({out_wr_alf, out_wr_phv_alf} !== {k[0], k[1]}) begin
                errors++;
                $display("FAIL alf_passthrough: got %b%b exp %b%b", out_wr_alf, out_wr_phv_alf, k[0], k[1]);
            end
        end
        in_wr_alf = 1'b0; in_wr_phv_alf = 1'b0;
        clear_obs();
        // 4-word packet to MID 5, payload 0xA..0xD
        phv = mk_phv(8'd5, 4'h1);
        for (int i = 0; i < 4; i++)
            pw[i] = {(i == 0) ? 2'b01 : ((i == 3) ? 2'b10 : 2'b11), 132'(4'hA + i)};
        send_pkt(phv, 4, 1'b1, 0);
        model_pkt(phv, 4, 1'b1);
        // Own MID but unknown opcode is forwarded too, with idle gaps.
        run_pkt(mk_phv(c_LMID, 4'h7), 5, 1'b0, 40);
        repeat (3) tick();
        checks++;
        if (q_fwd.size() !== e_fwd.size()) begin
            errors++;
            $display("FAIL fwd_count: got %0d exp %0d", q_fwd.size(), e_fwd.size());
        end
        for (int i = 0; i < e_fwd.size() && i < q_fwd.size(); i++) begin
            checks++;
            if (q_fwd[i] !== e_fwd[i]) begin
                errors++;
                $display("FAIL fwd_word[%0d]: got t=%0d vwr=%b v=%b d=%h exp t=%0d vwr=%b v=%b d=%h", i,
                         q_fwd[i].stamp, q_fwd[i].vwr, q_fwd[i].v, q_fwd[i].data,
                         e_fwd[i].stamp, e_fwd[i].vwr, e_fwd[i].v, e_fwd[i].data);
            end
        end
        checks++;
        if (q_phv.size() !== e_phv.size()) begin
            errors++;
            $display("FAIL fwd_phv_count: got %0d exp %0d", q_phv.size(), e_phv.size());
        end
        for (int i = 0; i < e_phv.size() && i < q_phv.size(); i++) begin
            checks++;
            if (q_phv[i] !== e_phv[i]) begin
                errors++;
                $display("FAIL fwd_phv[%0d]: got t=%0d top=%h exp t=%0d top=%h", i,
                         q_phv[i].stamp, q_phv[i].phv[1023:960], e_phv[i].stamp, e_phv[i].phv[1023:960]);
            end
        end
        checks++;
        if (q_ram.size() !== 0 || obs_err !== 0) begin
            errors++;
            $display("FAIL fwd_side_effects: got ram_writes=%0d errs=%0d exp 0 0", q_ram.size(), obs_err);
        end
        checks++;
        if ({pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag} !== {m_bypass, m_start, m_finish}) begin
            errors++;
            $display("FAIL fwd_flags: got %b%b%b exp %b%b%b", pgm_bypass_flag, pgm_sent_start_flag,
                     pgm_sent_finish_flag, m_bypass, m_start, m_finish);
        end
    endtask

    task automatic test_store();
        clear_obs();
        run_pkt(mk_phv(c_LMID, 4'h1), 3, 1'b1, 0);
        checks++;
        if (pgm_tpl_len !== m_len) begin
            errors++;
            $display("FAIL store_len: got %0d exp %0d", pgm_tpl_len, m_len);
        end
        repeat (2) tick();
        checks++;
        if (q_ram.size() !== e_ram.size()) begin
            errors++;
            $display("FAIL store_count: got %0d exp %0d", q_ram.size(), e_ram.size());
        end
        for (int i = 0; i < e_ram.size() && i < q_ram.size(); i++) begin
            checks++;
            if (q_ram[i] !== e_ram[i]) begin
                errors++;
                $display("FAIL store_write[%0d]: got t=%0d a=%0d d=%h exp t=%0d a=%0d d=%h", i,
                         q_ram[i].stamp, q_ram[i].addr, q_ram[i].wdata, e_ram[i].stamp, e_ram[i].addr, e_ram[i].wdata);
            end
        end
        checks++;
        if (q_fwd.size() !== 0 || q_phv.size() !== 0 || obs_err !== 0) begin
            errors++;
            $display("FAIL store_side_effects: got fwd=%0d phv=%0d errs=%0d exp 0 0 0", q_fwd.size(), q_phv.size(), obs_err);
        end
    endtask

    task automatic test_start_stop();
        clear_obs();
        run_pkt(mk_phv(c_LMID, 4'h2), 2, 1'b1, 0);
        checks++;
        if ({pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag} !== {m_bypass, m_start, m_finish}) begin
            errors++;
            $display("FAIL start_flags: got %b%b%b exp %b%b%b", pgm_bypass_flag, pgm_sent_start_flag,
                     pgm_sent_finish_flag, m_bypass, m_start, m_finish);
        end
        run_pkt(mk_phv(c_LMID, 4'h3), 3, 1'b1, 0);
        checks++;
        if ({pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag} !== {m_bypass, m_start, m_finish}) begin
            errors++;
            $display("FAIL stop_flags: got %b%b%b exp %b%b%b", pgm_bypass_flag, pgm_sent_start_flag,
                     pgm_sent_finish_flag, m_bypass, m_start, m_finish);
        end
        repeat (2) tick();
        checks++;
        if (q_fwd.size() !== 0 || q_ram.size() !== 0 || obs_err !== exp_err) begin
            errors++;
            $display("FAIL cmd_side_effects: got fwd=%0d ram=%0d errs=%0d exp 0 0 %0d",
                     q_fwd.size(), q_ram.size(), obs_err, exp_err);
        end
    endtask

    task automatic test_cmd_errors();
        clear_obs();
        run_pkt(mk_phv(c_LMID, 4'h1), 3, 1'b0, 0);   // discarded template
        checks++;
        if (pgm_tpl_len !== m_len) begin
            errors++;
            $display("FAIL bad_store_len: got %0d exp %0d", pgm_tpl_len, m_len);
        end
        run_pkt(mk_phv(c_LMID, 4'h2), 2, 1'b1, 0);   // START without template
        checks++;
        if ({pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag} !== {m_bypass, m_start, m_finish}) begin
            errors++;
            $display("FAIL notpl_start_flags: got %b%b%b exp %b%b%b", pgm_bypass_flag, pgm_sent_start_flag,
                     pgm_sent_finish_flag, m_bypass, m_start, m_finish);
        end
        run_pkt(mk_phv(c_LMID, 4'h1), 2, 1'b1, 0);
        run_pkt(mk_phv(c_LMID, 4'h2), 2, 1'b1, 0);
        run_pkt(mk_phv(c_LMID, 4'h1), 3, 1'b1, 0);   // STORE while generating
        checks++;
        if ({pgm_sent_start_flag, pgm_tpl_len} !== {m_start, m_len}) begin
            errors++;
            $display("FAIL busy_store_state: got start=%b len=%0d exp start=%b len=%0d",
                     pgm_sent_start_flag, pgm_tpl_len, m_start, m_len);
        end
        run_pkt(mk_phv(c_LMID, 4'h3), 2, 1'b1, 0);
        run_pkt(mk_phv(c_LMID, 4'h3), 2, 1'b1, 0);   // STOP when idle: no effect
        repeat (2) tick();
        checks++;
        if (q_ram.size() !== e_ram.size()) begin
            errors++;
            $display("FAIL cmderr_ram_count: got %0d exp %0d", q_ram.size(), e_ram.size());
        end
        for (int i = 0; i < e_ram.size() && i < q_ram.size(); i++) begin
            checks++;
            if (q_ram[i] !== e_ram[i]) begin
                errors++;
                $display("FAIL cmderr_write[%0d]: got t=%0d a=%0d exp t=%0d a=%0d", i,
                         q_ram[i].stamp, q_ram[i].addr, e_ram[i].stamp, e_ram[i].addr);
            end
        end
        checks++;
        if (obs_err !== exp_err) begin
            errors++;
            $display("FAIL cmderr_err_pulses: got %0d exp %0d", obs_err, exp_err);
        end
        checks++;
        if ({pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag} !== {m_bypass, m_start, m_finish}) begin
            errors++;
            $display("FAIL cmderr_flags: got %b%b%b exp %b%b%b", pgm_bypass_flag, pgm_sent_start_flag,
                     pgm_sent_finish_flag, m_bypass, m_start, m_finish);
        end
    endtask

    task automatic test_overflow();
        clear_obs();
        run_pkt(mk_phv(c_LMID, 4'h1), 130, 1'b1, 0);
        run_pkt(mk_phv(c_LMID, 4'h2), 2, 1'b1, 0);   // rejected: template invalid
        repeat (2) tick();
        checks++;
        if (q_ram.size() !== e_ram.size()) begin
            errors++;
            $display("FAIL ovf_count: got %0d exp %0d", q_ram.size(), e_ram.size());
        end
        for (int i = 0; i < e_ram.size() && i < q_ram.size(); i++) begin
            checks++;
            if (q_ram[i] !== e_ram[i]) begin
                errors++;
                $display("FAIL ovf_write[%0d]: got t=%0d a=%0d d=%h exp t=%0d a=%0d d=%h", i,
                         q_ram[i].stamp, q_ram[i].addr, q_ram[i].wdata, e_ram[i].stamp, e_ram[i].addr, e_ram[i].wdata);
            end
        end
        checks++;
        if (obs_err !== exp_err) begin
            errors++;
            $display("FAIL ovf_err_pulses: got %0d exp %0d", obs_err, exp_err);
        end
        checks++;
        if ({pgm_bypass_flag, pgm_sent_start_flag} !== {m_bypass, m_start}) begin
            errors++;
            $display("FAIL ovf_start_rejected: got bypass=%b start=%b exp bypass=%b start=%b",
                     pgm_bypass_flag, pgm_sent_start_flag, m_bypass, m_start);
        end
    endtask

    task automatic test_reset_mid();
        logic [1023:0] phv;
        int nz;
        phv = mk_phv(c_LMID, 4'h1);
        build_pkt(6);
        send_words(phv, 6, 1'b1, 0, 0, 2);
        rst_n = 1'b0;
        #1;
        nz = $countones({out_wr_phv, out_wr_phv_wr, out_wr_data, out_wr_data_wr, out_wr_valid,
                         out_wr_valid_wr, wr2ram_wr, wr2ram_addr, wr2ram_wdata, pgm_tpl_len, pgm_err});
        checks++;
        if (nz !== 0 || {pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag} !== 3'b100) begin
            errors++;
            $display("FAIL midreset_outputs: got %0d nonzero bits flags=%b exp 0 flags=100", nz,
                     {pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag});
        end
        send_words(phv, 6, 1'b1, 0, 2, 3);
        rst_n = 1'b1;
        model_reset();
        clear_obs();
        send_words(phv, 6, 1'b1, 0, 3, 6);         // leftover words must be ignored
        repeat (2) tick();
        checks++;
        if (q_ram.size() !== 0 || q_fwd.size() !== 0 || obs_err !== 0 || pgm_tpl_len !== 8'd0) begin
            errors++;
            $display("FAIL midreset_leftover: got ram=%0d fwd=%0d errs=%0d len=%0d exp 0 0 0 0",
                     q_ram.size(), q_fwd.size(), obs_err, pgm_tpl_len);
        end
        run_pkt(mk_phv(8'd9, 4'h0), 4, 1'b1, 0);
        repeat (2) tick();
        checks++;
        if (q_fwd.size() !== e_fwd.size()) begin
            errors++;
            $display("FAIL midreset_fwd_count: got %0d exp %0d", q_fwd.size(), e_fwd.size());
        end
        for (int i = 0; i < e_fwd.size() && i < q_fwd.size(); i++) begin
            checks++;
            if (q_fwd[i] !== e_fwd[i]) begin
                errors++;
                $display("FAIL midreset_fwd[%0d]: got t=%0d d=%h exp t=%0d d=%h", i,
                         q_fwd[i].stamp, q_fwd[i].data, e_fwd[i].stamp, e_fwd[i].data);
            end
        end
        checks++;
        if (q_phv.size() !== 1 || (q_phv.size() == 1 && q_phv[0] !== e_phv[0])) begin
            errors++;
            $display("FAIL midreset_phv: got count=%0d exp count=1 matching", q_phv.size());
        end
    endtask

    task automatic test_random();
        logic [1023:0] phv;
        logic [159:0]  r;
        int            kind, n;
        bit            good;
        clear_obs();
        for (int p = 0; p < 40; p++) begin
            kind = int'($urandom_range(3));
            good = ($urandom_range(3) != 0);
            phv  = rand_phv();
            case (kind)
                0: n = int'($urandom_range(2, 8));
                1: begin n = int'($urandom_range(2, 20)); phv[1023:1012] = {c_LMID, 4'h1}; end
                2: begin n = int'($urandom_range(2, 3));  phv[1023:1012] = {c_LMID, 4'h2}; end
                default: begin n = int'($urandom_range(2, 3)); phv[1023:1012] = {c_LMID, 4'h3}; end
            endcase
            if ($urandom_range(3) == 0) begin
                // Stray body word between packets
                r = {$urandom, $urandom, $urandom, $urandom, $urandom};
                in_wr_data = {2'b11, r[131:0]};
                in_wr_data_wr = 1'b1;
                tick();
                idle_inputs();
            end
            run_pkt(phv, n, good, 30);
            checks++;
            if ({pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag, pgm_tpl_len} !==
                {m_bypass, m_start, m_finish, m_len}) begin
                errors++;
                $display("FAIL rand_state[%0d]: got flags=%b%b%b len=%0d exp flags=%b%b%b len=%0d", p,
                         pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag, pgm_tpl_len,
                         m_bypass, m_start, m_finish, m_len);
            end
        end
        repeat (3) tick();
        checks++;
        if (q_ram.size() !== e_ram.size() || q_fwd.size() !== e_fwd.size() || q_phv.size() !== e_phv.size()) begin
            errors++;
            $display("FAIL rand_counts: got ram=%0d fwd=%0d phv=%0d exp ram=%0d fwd=%0d phv=%0d",
                     q_ram.size(), q_fwd.size(), q_phv.size(), e_ram.size(), e_fwd.size(), e_phv.size());
        end
        for (int i = 0; i < e_ram.size() && i < q_ram.size(); i++) begin
            checks++;
            if (q_ram[i] !== e_ram[i]) begin
                errors++;
                $display("FAIL rand_write[%0d]: got t=%0d a=%0d d=%h exp t=%0d a=%0d d=%h", i,
                         q_ram[i].stamp, q_ram[i].addr, q_ram[i].wdata, e_ram[i].stamp, e_ram[i].addr, e_ram[i].wdata);
            end
        end
        for (int i = 0; i < e_fwd.size() && i < q_fwd.size(); i++) begin
            checks++;
            if (q_fwd[i] !== e_fwd[i]) begin
                errors++;
                $display("FAIL rand_fwd[%0d]: got t=%0d vwr=%b v=%b d=%h exp t=%0d vwr=%b v=%b d=%h", i,
                         q_fwd[i].stamp, q_fwd[i].vwr, q_fwd[i].v, q_fwd[i].data,
                         e_fwd[i].stamp, e_fwd[i].vwr, e_fwd[i].v, e_fwd[i].data);
            end
        end
        for (int i = 0; i < e_phv.size() && i < q_phv.size(); i++) begin
            checks++;
            if (q_phv[i] !== e_phv[i]) begin
                errors++;
                $display("FAIL rand_phv[%0d]: got t=%0d top=%h exp t=%0d top=%h", i,
                         q_phv[i].stamp, q_phv[i].phv[1023:960], e_phv[i].stamp, e_phv[i].phv[1023:960]);
            end
        end
        checks++;
        if (obs_err !== exp_err) begin
            errors++;
            $display("FAIL rand_err_pulses: got %0d exp %0d", obs_err, exp_err);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_forward();
        test_store();
        test_start_stop();
        test_cmd_errors();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
